// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction-memory boot loader.
package imem_pkg;

    localparam int          IMEM_ADDR_W = 6;
    localparam int          IMEM_DEPTH  = 64;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_FILL,
        S_DONE
    } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word; word_full_o flags the 4th byte.
// Zero latency to word_full_o; the word register is valid the cycle after the 4th accept.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q,  idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (accept_i) begin
            for (int b = 0; b < 4; b++) begin
                if (idx_q == 2'(b)) begin
                    word_d[8*b +: 8] = byte_i;
                end
            end
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = accept_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into 32-bit words, writes them to imem, pads the rest with NOP.
// s_ready only in RECV; one write cycle per word, one per fill word; done follows the last write.
module imem_loader #(
    parameter int          ADDR_W   = imem_pkg::IMEM_ADDR_W,
    parameter int          DEPTH    = imem_pkg::IMEM_DEPTH,
    parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum
);
    import imem_pkg::*;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;   // word index while receiving, fill address while padding
    logic [7:0]        csum_q,  csum_d;
    logic              err_q,   err_d;
    logic              we_q,    we_d;

    logic              accept;
    logic              pk_clr;
    logic              word_full;
    logic [31:0]       pk_word;
    logic [ADDR_W:0]   next_idx;
    logic              legal;

    assign accept   = s_valid && (state_q == S_RECV);
    assign next_idx = {1'b0, addr_q} + (ADDR_W+1)'(1);
    assign legal    = (num_words != '0) && (num_words <= DEPTH_C);

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (pk_clr),
        .accept_i    (accept),
        .byte_i      (s_data),
        .word_o      (pk_word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        err_d   = 1'b0;
        pk_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        count_d = num_words;
                        addr_d  = '0;
                        csum_d  = '0;
                        pk_clr  = 1'b1;
                        state_d = S_RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    csum_d = csum_q + s_data;
                    if (word_full) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (next_idx < count_q) begin
                    addr_d  = next_idx[ADDR_W-1:0];
                    state_d = S_RECV;
                end else if (count_q < DEPTH_C) begin
                    addr_d  = count_q[ADDR_W-1:0];
                    state_d = S_FILL;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_FILL: begin
                if (addr_q == LAST_A) state_d = S_DONE;
                else                  addr_d  = addr_q + ADDR_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Strobe is registered alongside the state so it lines up with WRITE/FILL exactly.
        we_d = (state_d == S_WRITE) || (state_d == S_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    assign s_ready   = (state_q == S_RECV);
    assign busy      = (state_q != S_IDLE);
    assign cpu_hold  = busy;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign checksum  = csum_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = (state_q == S_FILL) ? NOP_WORD : pk_word;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a byte-queue reference model of the loaded image.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, s_valid;
    logic [6:0]  num_words;
    logic [7:0]  s_data;
    logic        s_ready, mem_we, busy, cpu_hold, done, err;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  checksum;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    int wr_addr[$];
    logic [31:0] wr_data[$];
    int wr_cyc[$];
    int done_cnt = 0, err_cnt = 0, done_cyc = 0;
    bit hold_at_done = 0;
    logic [7:0] bq[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            hold_at_done = cpu_hold && busy;
        end
        if (err) err_cnt++;
    end

    function automatic logic [31:0] exp_word(input int n, input int a);
        if (a < n) return {bq[4*a+3], bq[4*a+2], bq[4*a+1], bq[4*a]};
        return 32'h0000_0013;
    endfunction

    function automatic logic [7:0] exp_csum(input int nbytes);
        int s = 0;
        for (int i = 0; i < nbytes; i++) s += int'(bq[i]);
        return 8'(s % 256);
    endfunction

    task automatic fill_random(input int n);
        bq.delete();
        for (int i = 0; i < 4*n; i++) bq.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    endtask

    // mode 0: valid always; 1: fixed 1-0-0-1-1-0-1 pattern; 2: random gaps
    task automatic drive_load(input int n, input int mode, input int extra, input bit poke_start,
                              output int acc, output int extra_acc, output bit timeout);
        bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int k, d0;
        bit v;
        d0 = done_cnt;
        timeout = 0;
        clear_logs();
        @(negedge clk);
        start = 1'b1; num_words = n[6:0];
        @(negedge clk);
        start = 1'b0;
        acc = 0; k = 0;
        while (acc < 4*n && k < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = pat[k % 7];
                default: v = ($urandom_range(0, 99) >= 30);
            endcase
            s_valid = v;
            s_data  = v ? bq[acc] : 8'($urandom);
            if (poke_start && k == 3) begin start = 1'b1; num_words = 7'd0; end
            else start = 1'b0;
            if (s_valid && s_ready) acc++;
            @(negedge clk);
            k++;
        end
        if (k >= 2000) timeout = 1;
        start = 1'b0;
        extra_acc = 0;
        for (int i = 0; i < extra; i++) begin
            s_valid = 1'b1; s_data = 8'($urandom);
            if (s_ready) extra_acc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 300) begin @(negedge clk); k++; end
        if (done_cnt == d0) timeout = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_words = '0; s_valid = 1'b0; s_data = '0;
        #1;
        n_cmp++;
        if ({s_ready, mem_we, busy, cpu_hold, done, err, checksum, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b we=%b busy=%b hold=%b done=%b err=%b csum=%h addr=%h wdata=%h, want all 0",
                     s_ready, mem_we, busy, cpu_hold, done, err, checksum, mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_ready, busy, cpu_hold, mem_we} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got ready=%b busy=%b hold=%b we=%b, want 0", s_ready, busy, cpu_hold, mem_we);
        end
    endtask

    task automatic test_basic_load();
        int acc, xa; bit to;
        bq = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00};
        drive_load(2, 0, 0, 0, acc, xa, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to); end
        n_cmp++;
        if (wr_addr.size() != 64) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 64", wr_addr.size()); end
        for (int a = 0; a < 64 && a < wr_addr.size(); a++) begin
            n_cmp++;
            if (wr_addr[a] != a || wr_data[a] !== exp_word(2, a)) begin
                n_fail++;
                $display("FAIL basic_image[%0d]: got addr=%0d data=%h want addr=%0d data=%h", a, wr_addr[a], wr_data[a], a, exp_word(2, a));
            end
        end
        n_cmp++;
        if (wr_data.size() < 2 || wr_data[0] !== 32'h0050_0093 || wr_data[1] !== 32'h0050_0113) begin
            n_fail++; $display("FAIL basic_words: got first two writes wrong, want 00500093 00500113");
        end
        for (int a = 3; a < wr_cyc.size(); a++) begin
            n_cmp++;
            if (wr_cyc[a] - wr_cyc[a-1] != 1) begin n_fail++; $display("FAIL basic_fill_gap[%0d]: got %0d want 1", a, wr_cyc[a] - wr_cyc[a-1]); end
        end
        n_cmp++;
        if (wr_cyc.size() > 0 && done_cyc != wr_cyc[wr_cyc.size()-1] + 1) begin
            n_fail++; $display("FAIL basic_done_timing: got done at %0d want %0d", done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
        end
        n_cmp++; if (checksum !== 8'h47) begin n_fail++; $display("FAIL basic_checksum: got %h want 47", checksum); end
        n_cmp++; if (hold_at_done !== 1'b1) begin n_fail++; $display("FAIL basic_hold_at_done: got %b want 1", hold_at_done); end
        n_cmp++; if (cpu_hold !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_hold_after: got hold=%b busy=%b want 0", cpu_hold, busy); end
    endtask

    task automatic test_full_load();
        int acc, xa; bit to;
        fill_random(64);
        drive_load(64, 0, 0, 0, acc, xa, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %b want 0", to); end
        n_cmp++; if (wr_addr.size() != 64) begin n_fail++; $display("FAIL full_wr_count: got %0d want 64", wr_addr.size()); end
        for (int a = 0; a < 64 && a < wr_addr.size(); a++) begin
            n_cmp++;
            if (wr_addr[a] != a || wr_data[a] !== exp_word(64, a)) begin
                n_fail++;
                $display("FAIL full_image[%0d]: got addr=%0d data=%h want addr=%0d data=%h", a, wr_addr[a], wr_data[a], a, exp_word(64, a));
            end
            if (a > 0) begin
                n_cmp++;
                if (wr_cyc[a] - wr_cyc[a-1] != 5) begin n_fail++; $display("FAIL full_word_gap[%0d]: got %0d want 5", a, wr_cyc[a] - wr_cyc[a-1]); end
            end
        end
        n_cmp++;
        if (wr_cyc.size() > 0 && done_cyc != wr_cyc[wr_cyc.size()-1] + 1) begin
            n_fail++; $display("FAIL full_done_timing: got %0d want %0d", done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
        end
        n_cmp++; if (checksum !== exp_csum(256)) begin n_fail++; $display("FAIL full_checksum: got %h want %h", checksum, exp_csum(256)); end
    endtask

    task automatic test_err();
        logic [7:0] cs0;
        int n_bad[2] = '{0, 65};
        cs0 = checksum;
        clear_logs();
        foreach (n_bad[i]) begin
            @(negedge clk);
            start = 1'b1; num_words = n_bad[i][6:0];
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || mem_we !== 1'b0) begin
                n_fail++; $display("FAIL err_pulse_n%0d: got err=%b busy=%b ready=%b we=%b want 1 0 0 0", n_bad[i], err, busy, s_ready, mem_we);
            end
            @(negedge clk);
            n_cmp++;
            if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle_n%0d: got err=%b busy=%b want 0 0", n_bad[i], err, busy); end
        end
        n_cmp++; if (checksum !== cs0) begin n_fail++; $display("FAIL err_checksum: got %h want %h", checksum, cs0); end
        n_cmp++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL err_writes: got %0d want 0", wr_addr.size()); end
    endtask

    task automatic test_gaps();
        int acc, xa; bit to;
        bq = '{8'h13, 8'h00, 8'h00, 8'h00};
        drive_load(1, 1, 4, 0, acc, xa, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL gaps_timeout: got %b want 0", to); end
        n_cmp++; if (acc + xa != 4) begin n_fail++; $display("FAIL gaps_accepts: got %0d want 4", acc + xa); end
        n_cmp++;
        if (wr_addr.size() != 64 || wr_addr[0] != 0 || wr_data[0] !== 32'h0000_0013) begin
            n_fail++; $display("FAIL gaps_word0: got count=%0d first=%h want 64 00000013", wr_addr.size(), wr_data.size() ? wr_data[0] : 32'hx);
        end
        n_cmp++; if (checksum !== 8'h13) begin n_fail++; $display("FAIL gaps_checksum: got %h want 13", checksum); end
    endtask

    task automatic test_ignored(input int n, input int mode);
        int acc, xa, e0; bit to;
        fill_random(n);
        e0 = err_cnt;
        drive_load(n, mode, 8, 1, acc, xa, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL ign_timeout: got %b want 0", to); end
        n_cmp++; if (err_cnt != e0) begin n_fail++; $display("FAIL ign_err: got %0d err pulses want 0", err_cnt - e0); end
        n_cmp++; if (xa != 0) begin n_fail++; $display("FAIL ign_extra_accepts: got %0d want 0", xa); end
        n_cmp++; if (wr_addr.size() != 64) begin n_fail++; $display("FAIL ign_wr_count: got %0d want 64", wr_addr.size()); end
        for (int a = 0; a < 64 && a < wr_addr.size(); a++) begin
            n_cmp++;
            if (wr_addr[a] != a || wr_data[a] !== exp_word(n, a)) begin
                n_fail++;
                $display("FAIL ign_image[%0d]: got addr=%0d data=%h want addr=%0d data=%h", a, wr_addr[a], wr_data[a], a, exp_word(n, a));
            end
        end
        n_cmp++; if (checksum !== exp_csum(4*n)) begin n_fail++; $display("FAIL ign_checksum: got %h want %h", checksum, exp_csum(4*n)); end
    endtask

    task automatic test_reset_mid();
        int acc = 0, k = 0, d0;
        fill_random(5);
        clear_logs();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; num_words = 7'd5;
        @(negedge clk);
        start = 1'b0;
        while (acc < 9 && k < 100) begin
            s_valid = 1'b1; s_data = bq[acc];
            if (s_ready) acc++;
            @(negedge clk);
            k++;
        end
        s_valid = 1'b0;
        n_cmp++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL rstmid_pre_writes: got %0d want 2", wr_addr.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready, mem_we, busy, cpu_hold, done, err, checksum} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got ready=%b we=%b busy=%b hold=%b done=%b err=%b csum=%h want all 0",
                               s_ready, mem_we, busy, cpu_hold, done, err, checksum);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0); end
        test_ignored(7, 2);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_full_load();
        test_err();
        test_gaps();
        test_ignored(3, 0);
        test_ignored($urandom_range(1, 63), 2);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that fills the 64-word instruction memory from a byte stream, acting as its write-side initiator.
- Accepts bytes over a valid/ready stream and packs them little-endian into 32-bit instructions.
- Writes each instruction through a single-cycle write strobe, then pads the remaining words with NOP (ADDI x0,x0,0).
- Holds the CPU in stall for the whole load so fetch never reads a partially written image.

Parameters:
- ADDR_W, 6, word-address width of instruction memory.
- DEPTH, 64, number of 32-bit words in instruction memory (2**ADDR_W).
- NOP_WORD, 32'h00000013, fill value for words not supplied by the stream.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle load request; sampled only in IDLE.
- num_words  input  ADDR_W+1  number of words to load, sampled with start; legal range 1..DEPTH.
- s_valid  input  1  stream byte valid.
- s_data  input  8  stream byte.
- s_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  word address for write.
- mem_wdata  output  32  word to write.
- busy  output  1  load in progress.
- cpu_hold  output  1  stall request to the core/PC.
- done  output  1  one-cycle pulse when the load completes.
- err  output  1  one-cycle pulse when a start is rejected.
- checksum  output  8  mod-256 sum of all accepted bytes of the last load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; internal word, byte index, word index, count and checksum cleared.
- Reset mid-load: mem_we deasserts immediately; the partial image stays in memory; no done pulse.
- States: IDLE, RECV, WRITE, FILL, DONE.
- IDLE: s_ready=0, busy=0, cpu_hold=0.
  - start with num_words==0 or num_words>DEPTH: err=1 for the next cycle; stay IDLE; checksum unchanged.
  - start with legal num_words: latch count; clear word index, byte index and checksum; go RECV. busy and cpu_hold are 1 from the next cycle.
- RECV: s_ready=1.
  - A byte is accepted on s_valid&&s_ready.
  - The byte goes to word bits [8*byte_idx+7 : 8*byte_idx], so byte 0 lands in [7:0].
  - checksum += byte (wraps mod 256).
  - byte_idx increments; the acceptance with byte_idx==3 wraps byte_idx to 0 and goes WRITE.
  - s_valid low: state holds and no field changes.
- WRITE: s_ready=0; for exactly one cycle mem_we=1, mem_addr=word index, mem_wdata=assembled word. Next state:
  - word index+1 < count: word index increments; go RECV.
  - else if count < DEPTH: go FILL with fill address = count.
  - else: go DONE.
- FILL: s_ready=0; mem_we=1 every cycle with mem_wdata=NOP_WORD and mem_addr=fill address, incrementing by 1. After writing DEPTH-1, go DONE. No address wrap occurs.
- DONE: done=1 for one cycle; busy and cpu_hold stay 1 this cycle; go IDLE.
- Timing:
  - Minimum per supplied word: 4 accept cycles + 1 write cycle.
  - Fill takes DEPTH-count cycles.
  - done asserts the cycle after the last memory write.
- start while not in IDLE: ignored, with no err.
- mem_we is registered; mem_addr and mem_wdata are stable whenever mem_we=1 and are don't-care otherwise.
- s_data is ignored unless a byte is accepted.
- Bytes arriving after the last word: s_ready stays 0, so they are never accepted.

Decomposition:
- Package imem_pkg:
  - IMEM_ADDR_W=6, IMEM_DEPTH=64, NOP_WORD=32'h00000013.
  - Loader state enum (IDLE, RECV, WRITE, FILL, DONE).
- Sub-module byte_packer: a 4-byte little-endian shift/insert register with byte_idx counter and word_full flag. It owns the byte acceptance and assembled word; the top FSM owns addressing, fill and handshake outputs.

Test Plan:
1. Reset, then start with num_words=2, bytes 93 00 50 00 13 01 50 00 with s_valid held high.
   - Write addr0=0x00500093 and addr1=0x00500113, one mem_we cycle each.
   - FILL addr2..63 with 0x00000013 (62 cycles).
   - done pulse; checksum=0x47; cpu_hold is 0 after done.
2. Start with num_words=64, stream 256 bytes.
   - 64 writes, no FILL cycles.
   - Last write to addr 63; done on the next cycle.
3. Start with num_words=0, then separately with num_words=65.
   - err pulse for one cycle each; busy, mem_we and s_ready stay 0.
4. num_words=1, s_valid toggled 1-0-0-1-1-0-1 over bytes 13 00 00 00.
   - Exactly 4 accepts; single write addr0=0x00000013; byte order unaffected by the gaps.
5. Start during a load, and extra stream bytes after the last word.
   - Both are ignored: no err, s_ready=0, word count unchanged.
6. Assert rst_n=0 mid-RECV of word 3.
   - All outputs 0 immediately, including mem_we and cpu_hold.
   - No done pulse.
   - A fresh start then performs a complete correct load.
